// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel renderer and connector.
// frame_cnt exists only when FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        valid;
  logic        hsync;
  logic        vsync;
  logic        line_tick;
  logic        frame_tick;
`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt;

  modport master (output hc, vc, valid, hsync, vsync, line_tick, frame_tick, frame_cnt);
  modport slave  (input  hc, vc, valid, hsync, vsync, line_tick, frame_tick, frame_cnt);
`else
  modport master (output hc, vc, valid, hsync, vsync, line_tick, frame_tick);
  modport slave  (input  hc, vc, valid, hsync, vsync, line_tick, frame_tick);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster counters, visible decode, delayed syncs and line/frame strobes.
// Optional frame counter enabled by defining FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_ACTIVE = 1'b0,
  parameter int unsigned SYNC_DELAY  = 2
) (
  input  logic             clk_25m,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_LO   = H_VISIBLE + H_FP;
  localparam int unsigned HS_HI   = H_VISIBLE + H_FP + H_SYNC;
  localparam int unsigned VS_LO   = V_VISIBLE + V_FP;
  localparam int unsigned VS_HI   = V_VISIBLE + V_FP + V_SYNC;

  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;
  logic             h_last;
  logic             hsync_raw;
  logic             vsync_raw;

  assign h_last = (hc_q == CNT_W'(H_TOTAL - 1));

  // Counter advance: vc steps only on the hc wrap.
  always_comb begin
    hc_d = hc_q + CNT_W'(1);
    vc_d = vc_q;
    if (h_last) begin
      hc_d = '0;
      vc_d = (vc_q == CNT_W'(V_TOTAL - 1)) ? '0 : vc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // Raw decode yields the asserted level directly, so no inverter sits in the sync path.
  assign hsync_raw = (hc_q >= CNT_W'(HS_LO) && hc_q < CNT_W'(HS_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync_raw = (vc_q >= CNT_W'(VS_LO) && vc_q < CNT_W'(VS_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  assign vga.hc         = hc_q;
  assign vga.vc         = vc_q;
  assign vga.valid      = (hc_q < CNT_W'(H_VISIBLE)) && (vc_q < CNT_W'(V_VISIBLE));
  assign vga.line_tick  = ~rst & h_last;
  assign vga.frame_tick = ~rst & (hc_q == '0) & (vc_q == CNT_W'(V_VISIBLE));

  // Sync delay chain matching the renderer's RGB latency.
  if (SYNC_DELAY == 0) begin : g_no_delay
    assign vga.hsync = hsync_raw;
    assign vga.vsync = vsync_raw;
  end else begin : g_delay
    logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
    logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;

    always_comb begin
      hs_pipe_d = SYNC_DELAY'({hs_pipe_q, hsync_raw});
      vs_pipe_d = SYNC_DELAY'({vs_pipe_q, vsync_raw});
    end

    always_ff @(posedge clk_25m) begin
      if (rst) begin
        hs_pipe_q <= {SYNC_DELAY{~SYNC_ACTIVE}};
        vs_pipe_q <= {SYNC_DELAY{~SYNC_ACTIVE}};
      end else begin
        hs_pipe_q <= hs_pipe_d;
        vs_pipe_q <= vs_pipe_d;
      end
    end

    assign vga.hsync = hs_pipe_q[SYNC_DELAY-1];
    assign vga.vsync = vs_pipe_q[SYNC_DELAY-1];
  end

`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (vga.frame_tick) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_25m) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: small-geometry instances for full frames,
// a default-geometry instance for line-level timing; FRAME_CNT_EN adds counter checks.
module tb_vga_timing_gen;

  localparam int HV = 20, HF = 4, HS = 6, HB = 5, HT = HV + HF + HS + HB;
  localparam int VV = 10, VF = 2, VS = 3, VB = 4, VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;

  logic clk_25m = 1'b0;
  logic rst     = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   k       = 0;

  vga_timing_gen_if va ();
  vga_timing_gen_if vb ();
  vga_timing_gen_if vd ();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(1'b0), .SYNC_DELAY(2)
  ) dut (.clk_25m(clk_25m), .rst(rst), .vga(va));

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(1'b1), .SYNC_DELAY(0)
  ) dut_b (.clk_25m(clk_25m), .rst(rst), .vga(vb));

  vga_timing_gen dut_d (.clk_25m(clk_25m), .rst(rst), .vga(vd));

  always #20 clk_25m = ~clk_25m;

  // Reference model: k is the number of clock edges since reset was released.
  function automatic int ref_hc(int n, int ht);
    return n % ht;
  endfunction

  function automatic int ref_vc(int n, int ht, int vt);
    return (n / ht) % vt;
  endfunction

  function automatic bit ref_sync(int n, int d, bit act, int total, int lo, int hi, int unit);
    int pos;
    if (n < d) return ~act;
    pos = ((n - d) / unit) % total;
    return (pos >= lo && pos < hi) ? act : ~act;
  endfunction

  function automatic int ref_ticks(int n);
    if (n <= VV * HT) return 0;
    return (n - 1 - VV * HT) / FR + 1;
  endfunction

  task automatic tick();
    @(negedge clk_25m);
    #1;
    k++;
  endtask

  task automatic apply_reset(int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    #1;
    k = 0;
  endtask

  task automatic test_reset();
    int n;
    apply_reset(2);
    n = int'($urandom_range(FR / 3, 2 * FR / 3));
    repeat (n) tick();
    rst = 1'b1;
    repeat (3) begin
      tick();
      n_tests++;
      if (va.line_tick !== 1'b0 || va.frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ticks: line_tick=%b frame_tick=%b required 0 0", va.line_tick, va.frame_tick);
      end
    end
    rst = 1'b0;
    #1;
    k = 0;
    n_tests++;
    if (va.hc !== 10'd0 || va.vc !== 10'd0 || va.valid !== 1'b1 || va.hsync !== 1'b1 ||
        va.vsync !== 1'b1 || va.frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: hc=%0d vc=%0d valid=%b hs=%b vs=%b ft=%b required 0 0 1 1 1 0",
               va.hc, va.vc, va.valid, va.hsync, va.vsync, va.frame_tick);
    end
    n_tests++;
    if (vb.hsync !== 1'b0 || vb.vsync !== 1'b0 || vd.hc !== 10'd0 || vd.vc !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_other: b_hs=%b b_vs=%b d_hc=%0d d_vc=%0d required 0 0 0 0",
               vb.hsync, vb.vsync, vd.hc, vd.vc);
    end
    // Strobes must drop the instant rst rises, even on their own cycle.
    while (k % HT != HT - 1) tick();
    n_tests++;
    if (va.line_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL line_tick_pre_rst: got %b required 1", va.line_tick);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (va.line_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL line_tick_in_rst: got %b required 0", va.line_tick);
    end
    apply_reset(1);
    while (k < VV * HT) tick();
    n_tests++;
    if (va.frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_tick_pre_rst: got %b required 1", va.frame_tick);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (va.frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_tick_in_rst: got %b required 0", va.frame_tick);
    end
    apply_reset(2);
  endtask

  task automatic test_line_wrap();
    int h, v, low_cnt, first_low, last_low;
    bit exp_hs;
    low_cnt   = 0;
    first_low = -1;
    last_low  = -1;
    apply_reset(int'($urandom_range(1, 4)));
    while (k < 2 * 800 + 2) begin
      h      = ref_hc(k, 800);
      v      = ref_vc(k, 800, 525);
      exp_hs = ref_sync(k, 2, 1'b0, 800, 656, 752, 1);
      n_tests++;
      if (vd.hc !== 10'(h) || vd.vc !== 10'(v) || vd.valid !== (h < 640 && v < 480) ||
          vd.line_tick !== (h == 799) || vd.hsync !== exp_hs || vd.vsync !== 1'b1) begin
        n_fail++;
        $display("FAIL line_default k=%0d: hc=%0d vc=%0d valid=%b lt=%b hs=%b vs=%b required %0d %0d %b %b %b 1",
                 k, vd.hc, vd.vc, vd.valid, vd.line_tick, vd.hsync, vd.vsync,
                 h, v, (h < 640 && v < 480), (h == 799), exp_hs);
      end
      if (v == 1 && vd.hsync === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = h;
        last_low = h;
      end
      tick();
    end
    n_tests++;
    if (low_cnt != 96 || first_low != 658 || last_low != 753) begin
      n_fail++;
      $display("FAIL hsync_window: width=%0d first=%0d last=%0d required 96 658 753",
               low_cnt, first_low, last_low);
    end
  endtask

  task automatic test_frame();
    int h, v, ft_cnt, ft_k, vs_low;
    bit ha, va_s, hb, vb_s;
    ft_cnt = 0;
    ft_k   = -1;
    vs_low = 0;
    apply_reset(int'($urandom_range(1, 4)));
    while (k < 2 * FR + 40) begin
      h    = ref_hc(k, HT);
      v    = ref_vc(k, HT, VT);
      ha   = ref_sync(k, 2, 1'b0, HT, HV + HF, HV + HF + HS, 1);
      va_s = ref_sync(k, 2, 1'b0, VT, VV + VF, VV + VF + VS, HT);
      hb   = ref_sync(k, 0, 1'b1, HT, HV + HF, HV + HF + HS, 1);
      vb_s = ref_sync(k, 0, 1'b1, VT, VV + VF, VV + VF + VS, HT);
      n_tests++;
      if (va.hc !== 10'(h) || va.vc !== 10'(v) || va.valid !== (h < HV && v < VV) ||
          va.line_tick !== (h == HT - 1) || va.frame_tick !== (h == 0 && v == VV) ||
          va.hsync !== ha || va.vsync !== va_s) begin
        n_fail++;
        $display("FAIL frame_a k=%0d: hc=%0d vc=%0d valid=%b lt=%b ft=%b hs=%b vs=%b required %0d %0d %b %b %b %b %b",
                 k, va.hc, va.vc, va.valid, va.line_tick, va.frame_tick, va.hsync, va.vsync,
                 h, v, (h < HV && v < VV), (h == HT - 1), (h == 0 && v == VV), ha, va_s);
      end
      n_tests++;
      if (vb.hc !== 10'(h) || vb.vc !== 10'(v) || vb.hsync !== hb || vb.vsync !== vb_s) begin
        n_fail++;
        $display("FAIL frame_b k=%0d: hc=%0d vc=%0d hs=%b vs=%b required %0d %0d %b %b",
                 k, vb.hc, vb.vc, vb.hsync, vb.vsync, h, v, hb, vb_s);
      end
      if (va.frame_tick === 1'b1) begin
        ft_cnt++;
        if (ft_k < 0) ft_k = k;
      end
      if (k < FR && va.vsync === 1'b0) vs_low++;
      tick();
    end
    n_tests++;
    if (ft_cnt != 2 || ft_k != VV * HT) begin
      n_fail++;
      $display("FAIL frame_tick_count: count=%0d first_k=%0d required 2 %0d", ft_cnt, ft_k, VV * HT);
    end
    n_tests++;
    if (vs_low != VS * HT) begin
      n_fail++;
      $display("FAIL vsync_width: got %0d required %0d", vs_low, VS * HT);
    end
  endtask

  task automatic test_back_to_back();
    int h, v, len;
    bit ha, va_s;
    for (int it = 0; it < 4; it++) begin
      apply_reset(int'($urandom_range(1, 5)));
      len = int'($urandom_range(3, FR + HT));
      while (k < len) begin
        h    = ref_hc(k, HT);
        v    = ref_vc(k, HT, VT);
        ha   = ref_sync(k, 2, 1'b0, HT, HV + HF, HV + HF + HS, 1);
        va_s = ref_sync(k, 2, 1'b0, VT, VV + VF, VV + VF + VS, HT);
        n_tests++;
        if (va.hc !== 10'(h) || va.vc !== 10'(v) || va.hsync !== ha || va.vsync !== va_s) begin
          n_fail++;
          $display("FAIL b2b it=%0d k=%0d: hc=%0d vc=%0d hs=%b vs=%b required %0d %0d %b %b",
                   it, k, va.hc, va.vc, va.hsync, va.vsync, h, v, ha, va_s);
        end
        tick();
      end
    end
  endtask

`ifdef FRAME_CNT_EN
  task automatic test_frame_cnt();
    int budget;
    bit seen;
    apply_reset(2);
    while (k < 3 * FR + 5) begin
      n_tests++;
      if (va.frame_cnt !== 16'(ref_ticks(k))) begin
        n_fail++;
        $display("FAIL frame_cnt k=%0d: got %0d required %0d", k, va.frame_cnt, ref_ticks(k));
      end
      tick();
    end
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    #1;
    seen   = 1'b0;
    budget = FR + 2;
    while (!seen && budget > 0) begin
      seen = (va.frame_tick === 1'b1);
      n_tests++;
      if (va.frame_cnt !== 16'hFFFF) begin
        n_fail++;
        $display("FAIL frame_cnt_hold: got %0d required 65535", va.frame_cnt);
      end
      tick();
      budget--;
    end
    n_tests++;
    if (!seen || va.frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL frame_cnt_wrap: seen=%b got %0d required 1 0", seen, va.frame_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line_wrap();
    test_frame();
    test_back_to_back();
`ifdef FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
